// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 arrow-key decoder.
// Optional parity enforcement is selected with the PS2_PARITY_CHECK_EN macro.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } frame_state_t;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   // 2 ms at 50 MHz
   localparam int PS2_TIMEOUT_DEFAULT = 100000;

   // PS/2 uses odd parity over the eight data bits plus the parity bit
   function automatic logic odd_parity_ok(input logic [7:0] i_data, input logic i_par);
      return ^{i_data, i_par};
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizers, falling-edge detect, frame FSM and mid-frame timeout.
// Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_dat,
   output logic [7:0] o_byte,
   output logic       o_good,
   output logic       o_err
);

`ifdef PS2_PARITY_CHECK_EN
   localparam logic PARITY_EN = 1'b1;
`else
   localparam logic PARITY_EN = 1'b0;
`endif

   localparam logic [16:0] TO_LAST = 17'(TIMEOUT_CYCLES - 1);

   logic         r_clk_s1;
   logic         r_clk_s2;
   logic         r_clk_prev;
   logic         r_dat_s1;
   logic         r_dat_s2;
   frame_state_t r_state;
   logic [7:0]   r_shift;
   logic [2:0]   r_bitcnt;
   logic         r_parity;
   logic [16:0]  r_cnt;

   frame_state_t w_state_nxt;
   logic [7:0]   w_shift_nxt;
   logic [2:0]   w_bitcnt_nxt;
   logic         w_parity_nxt;
   logic [16:0]  w_cnt_nxt;
   logic         w_fall;
   logic         w_timeout;
   logic         w_par_ok;
   logic         w_good;
   logic         w_err;

   assign w_fall    = r_clk_prev & ~r_clk_s2;
   assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_cnt == TO_LAST);
   assign w_par_ok  = odd_parity_ok(r_shift, r_parity);

   // Synchronizers, edge register, FSM state and frame datapath
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_clk_prev <= 1'b1;
         r_dat_s1   <= 1'b1;
         r_dat_s2   <= 1'b1;
         r_state    <= ST_IDLE;
         r_shift    <= 8'h00;
         r_bitcnt   <= 3'd0;
         r_parity   <= 1'b0;
         r_cnt      <= 17'd0;
      end else begin
         r_clk_s1   <= i_ps2_clk;
         r_clk_s2   <= r_clk_s1;
         r_clk_prev <= r_clk_s2;
         r_dat_s1   <= i_ps2_dat;
         r_dat_s2   <= r_dat_s1;
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_bitcnt   <= w_bitcnt_nxt;
         r_parity   <= w_parity_nxt;
         r_cnt      <= w_cnt_nxt;
      end
   end

   // Frame FSM next state, datapath update and result strobes
   always_comb begin
      w_state_nxt  = r_state;
      w_shift_nxt  = r_shift;
      w_bitcnt_nxt = r_bitcnt;
      w_parity_nxt = r_parity;
      w_good       = 1'b0;
      w_err        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_fall && !r_dat_s2) begin
               w_state_nxt  = ST_DATA;
               w_bitcnt_nxt = 3'd0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (w_fall) begin
               w_shift_nxt  = {r_dat_s2, r_shift[7:1]};
               w_bitcnt_nxt = r_bitcnt + 3'd1;
               if (r_bitcnt == 3'd7) begin
                  w_state_nxt = ST_PARITY;
               end else begin
                  w_state_nxt = ST_DATA;
               end
            end else begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (w_fall) begin
               w_parity_nxt = r_dat_s2;
               w_state_nxt  = ST_STOP;
            end else begin
               w_state_nxt = ST_PARITY;
            end
         end
         ST_STOP: begin
            if (w_fall) begin
               w_state_nxt = ST_IDLE;
               if (r_dat_s2 && (w_par_ok || !PARITY_EN)) begin
                  w_good = 1'b1;
               end else begin
                  w_err = 1'b1;
               end
            end else begin
               w_state_nxt = ST_STOP;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // A stalled keyboard clock overrides whatever the frame was doing
      if (w_timeout) begin
         w_state_nxt = ST_IDLE;
         w_err       = 1'b1;
      end else begin
         w_err = w_err;
      end
   end

   // Idle counter: restarts on every edge, runs only while a frame is open
   always_comb begin
      if (w_fall || (r_state == ST_IDLE)) begin
         w_cnt_nxt = 17'd0;
      end else begin
         w_cnt_nxt = r_cnt + 17'd1;
      end
   end

   assign o_byte = r_shift;
   assign o_good = w_good;
   assign o_err  = w_err;

endmodule

// File: rtl/ps2_arrow_decoder.sv
// PS/2 keyboard to active-low cursor direction decoder (arrow keys, E0-extended).
// Build option: define PS2_PARITY_CHECK_EN to discard bytes with bad parity.
module ps2_arrow_decoder
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [1:0] dir_x,
   output logic [1:0] dir_y,
   output logic [7:0] scan_code,
   output logic       code_valid,
   output logic       frame_err
);

   logic [7:0] w_byte;
   logic       w_good;
   logic       w_err;

   logic       r_ext;
   logic       r_brk;
   logic       r_up;
   logic       r_down;
   logic       r_left;
   logic       r_right;

   logic       w_ext_nxt;
   logic       w_brk_nxt;
   logic       w_up_nxt;
   logic       w_down_nxt;
   logic       w_left_nxt;
   logic       w_right_nxt;
   logic [1:0] w_dir_x_nxt;
   logic [1:0] w_dir_y_nxt;

   ps2_rx_frame #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .i_clk     (CLOCK_50),
      .i_rst_n   (resetn),
      .i_ps2_clk (PS2_CLK),
      .i_ps2_dat (PS2_DAT),
      .o_byte    (w_byte),
      .o_good    (w_good),
      .o_err     (w_err)
   );

   // Prefix flags and held-key bits driven by each good byte
   always_comb begin
      w_ext_nxt   = r_ext;
      w_brk_nxt   = r_brk;
      w_up_nxt    = r_up;
      w_down_nxt  = r_down;
      w_left_nxt  = r_left;
      w_right_nxt = r_right;

      if (w_good) begin
         if (w_byte == SC_EXT) begin
            w_ext_nxt = 1'b1;
         end else if (w_byte == SC_BRK) begin
            w_brk_nxt = 1'b1;
         end else begin
            if (r_ext) begin
               case (w_byte)
                  SC_UP:    w_up_nxt    = ~r_brk;
                  SC_DOWN:  w_down_nxt  = ~r_brk;
                  SC_LEFT:  w_left_nxt  = ~r_brk;
                  SC_RIGHT: w_right_nxt = ~r_brk;
                  default:  w_up_nxt    = r_up;
               endcase
            end else begin
               w_up_nxt = r_up;
            end
            w_ext_nxt = 1'b0;
            w_brk_nxt = 1'b0;
         end
      end else begin
         w_ext_nxt = r_ext;
      end
   end

   // Opposite keys held together cancel to no motion on that axis
   always_comb begin
      if (w_left_nxt && w_right_nxt) begin
         w_dir_x_nxt = 2'b11;
      end else begin
         w_dir_x_nxt = {~w_left_nxt, ~w_right_nxt};
      end
      if (w_up_nxt && w_down_nxt) begin
         w_dir_y_nxt = 2'b11;
      end else begin
         w_dir_y_nxt = {~w_up_nxt, ~w_down_nxt};
      end
   end

   // Registered key state and outputs
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         r_ext      <= 1'b0;
         r_brk      <= 1'b0;
         r_up       <= 1'b0;
         r_down     <= 1'b0;
         r_left     <= 1'b0;
         r_right    <= 1'b0;
         dir_x      <= 2'b11;
         dir_y      <= 2'b11;
         scan_code  <= 8'h00;
         code_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         r_ext      <= w_ext_nxt;
         r_brk      <= w_brk_nxt;
         r_up       <= w_up_nxt;
         r_down     <= w_down_nxt;
         r_left     <= w_left_nxt;
         r_right    <= w_right_nxt;
         dir_x      <= w_dir_x_nxt;
         dir_y      <= w_dir_y_nxt;
         scan_code  <= w_good ? w_byte : scan_code;
         code_valid <= w_good;
         frame_err  <= w_err;
      end
   end

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Self-checking bench for ps2_arrow_decoder: directed scenarios plus randomized frames
// compared against a key-state reference model. Honours PS2_PARITY_CHECK_EN.
module tb_ps2_arrow_decoder;

   localparam int TO = 300;
   localparam int HP = 12;

   logic       CLOCK_50;
   logic       resetn;
   logic       PS2_CLK;
   logic       PS2_DAT;
   logic [1:0] dir_x;
   logic [1:0] dir_y;
   logic [7:0] scan_code;
   logic       code_valid;
   logic       frame_err;

   int n_checks  = 0;
   int n_errors  = 0;
   int n_valid   = 0;
   int n_err     = 0;
   int exp_valid = 0;
   int exp_err   = 0;

   bit         m_ext, m_brk;
   bit         m_up, m_down, m_left, m_right;
   logic [7:0] m_scan;

   ps2_arrow_decoder #(
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .resetn     (resetn),
      .PS2_CLK    (PS2_CLK),
      .PS2_DAT    (PS2_DAT),
      .dir_x      (dir_x),
      .dir_y      (dir_y),
      .scan_code  (scan_code),
      .code_valid (code_valid),
      .frame_err  (frame_err)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   // Strobe counters, sampled away from the active edge
   always @(negedge CLOCK_50) begin
      if (code_valid === 1'b1) n_valid <= n_valid + 1;
      if (frame_err === 1'b1) n_err <= n_err + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] axis(input bit inc, input bit dec);
      if (inc && dec) return 2'b11;
      return {~dec, ~inc};
   endfunction

   function automatic void model_reset();
      m_ext = 0; m_brk = 0;
      m_up = 0; m_down = 0; m_left = 0; m_right = 0;
      m_scan = 8'h00;
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      m_scan = b;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         if (m_ext) begin
            if (b == 8'h75) m_up    = !m_brk;
            if (b == 8'h72) m_down  = !m_brk;
            if (b == 8'h6B) m_left  = !m_brk;
            if (b == 8'h74) m_right = !m_brk;
         end
         m_ext = 0;
         m_brk = 0;
      end
   endfunction

   task automatic ps2_bit(input logic v);
      @(negedge CLOCK_50) PS2_DAT = v;
      repeat (HP) @(negedge CLOCK_50);
      PS2_CLK = 1'b0;
      repeat (HP) @(negedge CLOCK_50);
      PS2_CLK = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic par;
      bit   good;
      bit   seen;
      par = ~(^b);
      if (bad_par) par = ~par;
`ifdef PS2_PARITY_CHECK_EN
      good = !bad_stop && !bad_par;
`else
      good = !bad_stop;
`endif
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(par);
      @(negedge CLOCK_50) PS2_DAT = ~bad_stop;
      repeat (HP) @(negedge CLOCK_50);
      PS2_CLK = 1'b0;
      if (good) begin
         model_byte(b);
         exp_valid++;
      end else begin
         exp_err++;
      end
      seen = 0;
      for (int i = 0; i < HP; i++) begin
         @(negedge CLOCK_50);
         if (!seen && good && code_valid === 1'b1) begin
            seen = 1;
            check_eq("scan_code", 32'(scan_code), 32'(m_scan));
            check_eq("dir_x", 32'(dir_x), 32'(axis(m_right, m_left)));
            check_eq("dir_y", 32'(dir_y), 32'(axis(m_down, m_up)));
         end
         if (!seen && !good && frame_err === 1'b1) seen = 1;
      end
      check_eq(good ? "valid_strobe" : "err_strobe", 32'(seen), 32'd1);
      PS2_CLK = 1'b1;
      @(negedge CLOCK_50);
      check_eq("n_valid", 32'(n_valid), 32'(exp_valid));
      check_eq("n_err", 32'(n_err), 32'(exp_err));
   endtask

   task automatic send_good(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b0);
   endtask

   task automatic pulse_reset(input int cycles);
      @(negedge CLOCK_50) resetn = 1'b0;
      repeat (cycles) @(negedge CLOCK_50);
      resetn = 1'b1;
      model_reset();
   endtask

   initial begin
      int         sel;
      logic [7:0] b;
      logic [7:0] arrows [4];
      arrows[0] = 8'h75; arrows[1] = 8'h72; arrows[2] = 8'h6B; arrows[3] = 8'h74;

      PS2_CLK = 1'b1;
      PS2_DAT = 1'b1;
      resetn  = 1'b0;
      model_reset();
      repeat (5) @(negedge CLOCK_50);
      resetn = 1'b1;
      @(negedge CLOCK_50);
      check_eq("rst_dir_x", 32'(dir_x), 32'h3);
      check_eq("rst_dir_y", 32'(dir_y), 32'h3);
      check_eq("rst_scan", 32'(scan_code), 32'h00);
      check_eq("rst_valid", 32'(code_valid), 32'h0);
      check_eq("rst_err", 32'(frame_err), 32'h0);

      // Right key make then break
      send_good(8'hE0); send_good(8'h74);
      check_eq("right_make", 32'(dir_x), 32'h2);
      send_good(8'hE0); send_good(8'hF0); send_good(8'h74);
      check_eq("right_break", 32'(dir_x), 32'h3);

      // Non-arrow key
      send_good(8'h1C);
      check_eq("nonarrow_scan", 32'(scan_code), 32'h1C);
      check_eq("nonarrow_x", 32'(dir_x), 32'h3);
      check_eq("nonarrow_y", 32'(dir_y), 32'h3);

      // Up key with corrupted parity
      send_good(8'hE0);
      send_frame(8'h75, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
      check_eq("badpar_dir_y", 32'(dir_y), 32'h3);
`else
      check_eq("badpar_dir_y", 32'(dir_y), 32'h1);
`endif
      send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
      check_eq("up_clear", 32'(dir_y), 32'h3);

      // Opposite keys cancel
      send_good(8'hE0); send_good(8'h74);
      send_good(8'hE0); send_good(8'h6B);
      check_eq("opposite_x", 32'(dir_x), 32'h3);
      send_good(8'hE0); send_good(8'hF0); send_good(8'h6B);
      check_eq("left_release", 32'(dir_x), 32'h2);
      send_good(8'hE0); send_good(8'hF0); send_good(8'h74);

      // Bad stop bit is always discarded
      send_frame(8'h5A, 1'b0, 1'b1);
      check_eq("badstop_scan", 32'(scan_code), 32'h74);

      // Mid-frame timeout
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)));
      exp_err++;
      repeat (TO + 8) @(negedge CLOCK_50);
      check_eq("timeout_err", 32'(n_err), 32'(exp_err));
      check_eq("timeout_valid", 32'(n_valid), 32'(exp_valid));
      send_good(8'hE0); send_good(8'h72);
      check_eq("down_make", 32'(dir_y), 32'h2);

      // Reset between prefix and key code
      send_good(8'hE0);
      pulse_reset(1);
      @(negedge CLOCK_50);
      check_eq("midrst_scan", 32'(scan_code), 32'h00);
      check_eq("midrst_dir_y", 32'(dir_y), 32'h3);
      send_good(8'h72);
      check_eq("after_rst_scan", 32'(scan_code), 32'h72);
      check_eq("after_rst_dir_y", 32'(dir_y), 32'h3);

      // Randomized traffic
      for (int n = 0; n < 100; n++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 2) b = 8'hE0;
         else if (sel == 3) b = 8'hF0;
         else if (sel <= 7) b = arrows[$urandom_range(0, 3)];
         else b = 8'($urandom);
         send_frame(b, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
         repeat ($urandom_range(0, 20)) @(negedge CLOCK_50);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
